// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter slice.
// The default configuration here fixes the address and requester-index widths.
package regfile_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_NREQ  = 3;
  localparam int DEF_NREGS = 32;

  localparam int ADDR_W = $clog2(DEF_NREGS);
  localparam int REQ_W  = $clog2(DEF_NREQ);

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [REQ_W-1:0] req_id_t;

  localparam req_id_t REQ_WB  = req_id_t'(0);
  localparam req_id_t REQ_MC  = req_id_t'(1);
  localparam req_id_t REQ_DBG = req_id_t'(2);

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake plus the registered write port toward the register file.
// master = requesters/integration side, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int N     = regfile_pkg::DEF_N,
  parameter int NREQ  = regfile_pkg::DEF_NREQ,
  parameter int NREGS = regfile_pkg::DEF_NREGS
);
  localparam int AW  = $clog2(NREGS);
  localparam int IDW = $clog2(NREQ);

  logic                 rf_hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*N-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREGS-1:0]     rf_enable;
  logic [N-1:0]         rf_data;
  logic [IDW-1:0]       grant_id;
  logic                 wr_valid;

  modport master (
    output rf_hold, req_valid, req_addr, req_data,
    input  req_ready, rf_enable, rf_data, grant_id, wr_valid
  );

  modport slave (
    input  rf_hold, req_valid, req_addr, req_data,
    output req_ready, rf_enable, rf_data, grant_id, wr_valid
  );

endinterface

// File: rtl/regfile_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module regfile_rr_arbiter #(
  parameter int NREQ = regfile_pkg::DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  input  logic            hold,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int unsigned    pos;
  logic [IDW-1:0] pos_i;

  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = 0;
    pos_i = '0;
    if (!hold) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        pos   = (32'(last) + k) % NREQ;
        pos_i = IDW'(pos);
        if (grant == '0 && valid[pos_i]) begin
          grant[pos_i] = 1'b1;
          idx          = pos_i;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ requesters (round-robin, valid/ready)
// and drives a registered one-hot enable / data stage; writes to x0 are swallowed.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NREQ  = DEF_NREQ,
  parameter int NREGS = DEF_NREGS
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int AW  = $clog2(NREGS);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   last;
  logic [IDW-1:0]   gidx;
  logic [NREQ-1:0]  grant;
  logic             hs;
  logic [AW-1:0]    sel_addr;
  logic [N-1:0]     sel_data;
  logic [NREGS-1:0] dec;

  // Reset also suppresses grants so no handshake can complete while it is held.
  regfile_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid (bus.req_valid),
    .last  (last),
    .hold  (bus.rf_hold | reset),
    .grant (grant),
    .idx   (gidx)
  );

  assign bus.req_ready = grant;
  assign hs            = |(grant & bus.req_valid);

  always_comb begin
    sel_addr = bus.req_addr[gidx*AW +: AW];
    sel_data = bus.req_data[gidx*N +: N];
  end

  always_comb begin
    dec = '0;
    if (sel_addr != AW'(REG_ZERO)) dec[sel_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last          <= IDW'(NREQ - 1);
      bus.rf_enable <= '0;
      bus.rf_data   <= '0;
      bus.grant_id  <= '0;
      bus.wr_valid  <= 1'b0;
    end else begin
      bus.wr_valid  <= hs;
      bus.rf_enable <= hs ? dec : '0;
      if (hs) begin
        last         <= gidx;
        bus.rf_data  <= sel_data;
        bus.grant_id <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (N=32, NREQ=3, NREGS=32).
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_write_arbiter_if #(.N(32), .NREQ(3), .NREGS(32)) bus ();

  regfile_write_arbiter #(.N(32), .NREQ(3), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters must keep a pending request stable until it is accepted.
  for (genvar i = 0; i < 3; i++) begin : g_stable
    assert property (@(posedge clk) disable iff (reset)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (bus.req_valid[i] && $stable(bus.req_addr[i*5 +: 5]) && $stable(bus.req_data[i*32 +: 32])))
      else $error("requester %0d changed a pending request", i);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rf_hold   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(0, 5'd3, 32'hA000_0000);
    set_req(1, 5'd4, 32'hA000_0001);
    set_req(2, 5'd6, 32'hA000_0002);
    bus.req_valid = 3'b111;
    tick();
    checks++; if (bus.rf_enable !== 32'h0) begin errors++; $display("FAIL reset_rf_enable got %h want %h", bus.rf_enable, 32'h0); end
    checks++; if (bus.rf_data !== 32'h0) begin errors++; $display("FAIL reset_rf_data got %h want %h", bus.rf_data, 32'h0); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", bus.grant_id); end
    checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", bus.wr_valid); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", bus.req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant got %b want 001", bus.req_ready); end
    tick();
    checks++; if (bus.grant_id !== REQ_WB) begin errors++; $display("FAIL reset_first_id got %0d want 0", bus.grant_id); end
    checks++; if (bus.rf_enable !== 32'h0000_0008) begin errors++; $display("FAIL reset_first_en got %h want %h", bus.rf_enable, 32'h8); end
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL reset_next_ready got %b want 010", bus.req_ready); end
  endtask

  task automatic test_single_write;
    do_reset();
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    bus.req_valid = 3'b010;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (bus.rf_enable !== 32'h0000_0020) begin errors++; $display("FAIL single_en got %h want %h", bus.rf_enable, 32'h20); end
    checks++; if (bus.rf_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h want %h", bus.rf_data, 32'hDEADBEEF); end
    checks++; if (bus.grant_id !== REQ_MC) begin errors++; $display("FAIL single_id got %0d want 1", bus.grant_id); end
    checks++; if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL single_wr_valid got %b want 1", bus.wr_valid); end
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL single_idle_ready got %b want 000", bus.req_ready); end
    tick();
    checks++; if (bus.rf_enable !== 32'h0) begin errors++; $display("FAIL single_en_clear got %h want %h", bus.rf_enable, 32'h0); end
    checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL single_wr_clear got %b want 0", bus.wr_valid); end
    checks++; if (bus.rf_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data_hold got %h want %h", bus.rf_data, 32'hDEADBEEF); end
  endtask

  task automatic test_x0_write;
    set_req(0, 5'd0, 32'h0000_1234);
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL x0_ready got %b want 001", bus.req_ready); end
    tick();
    bus.req_valid = 3'b000;
    checks++; if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL x0_wr_valid got %b want 1", bus.wr_valid); end
    checks++; if (bus.rf_enable !== 32'h0) begin errors++; $display("FAIL x0_en got %h want %h", bus.rf_enable, 32'h0); end
    checks++; if (bus.rf_data !== 32'h0000_1234) begin errors++; $display("FAIL x0_data got %h want %h", bus.rf_data, 32'h1234); end
    checks++; if (bus.grant_id !== REQ_WB) begin errors++; $display("FAIL x0_id got %0d want 0", bus.grant_id); end
  endtask

  task automatic test_contention;
    logic [4:0] addrs [3];
    req_id_t    exp_id;
    logic [2:0] exp_rdy;
    logic [31:0] exp_en;
    addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd3;
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, addrs[i], 32'hC000_0000 + 32'(i));
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_id  = req_id_t'(k % 3);
      exp_rdy = 3'b001 << exp_id;
      exp_en  = 32'h1 << addrs[exp_id];
      #1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, exp_rdy); end
      @(posedge clk);
      #1;
      checks++; if (bus.grant_id !== exp_id || bus.wr_valid !== 1'b1 || bus.rf_enable !== exp_en)
        begin errors++; $display("FAIL rr_write[%0d] got id %0d wv %b en %h want id %0d wv 1 en %h", k, bus.grant_id, bus.wr_valid, bus.rf_enable, exp_id, exp_en); end
    end
  endtask

  task automatic test_hold;
    do_reset();
    set_req(0, 5'd10, 32'h1111_0000);
    set_req(1, 5'd11, 32'h2222_0000);
    set_req(2, 5'd12, 32'h3333_0000);
    bus.req_valid = 3'b111;
    tick();
    tick();
    tick();
    bus.rf_hold = 1'b1;
    checks++; if (bus.rf_enable !== 32'h0000_1000 || bus.grant_id !== REQ_DBG || bus.wr_valid !== 1'b1)
      begin errors++; $display("FAIL hold_inflight got en %h id %0d wv %b want en %h id 2 wv 1", bus.rf_enable, bus.grant_id, bus.wr_valid, 32'h1000); end
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready0 got %b want 000", bus.req_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus.req_ready !== 3'b000 || bus.wr_valid !== 1'b0 || bus.rf_enable !== 32'h0)
        begin errors++; $display("FAIL hold_idle[%0d] got rdy %b wv %b en %h want rdy 000 wv 0 en 0", k, bus.req_ready, bus.wr_valid, bus.rf_enable); end
    end
    bus.rf_hold = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL hold_resume_ready got %b want 001", bus.req_ready); end
    tick();
    checks++; if (bus.grant_id !== REQ_WB || bus.rf_data !== 32'h1111_0000)
      begin errors++; $display("FAIL hold_resume got id %0d data %h want id 0 data %h", bus.grant_id, bus.rf_data, 32'h11110000); end
  endtask

  task automatic test_single_repeat;
    do_reset();
    set_req(2, 5'd31, 32'h5A5A_5A5A);
    bus.req_valid = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL repeat_ready[%0d] got %b want 100", k, bus.req_ready); end
      @(posedge clk);
      #1;
      checks++; if (bus.grant_id !== REQ_DBG || bus.wr_valid !== 1'b1 || bus.rf_enable !== 32'h8000_0000)
        begin errors++; $display("FAIL repeat_write[%0d] got id %0d wv %b en %h want id 2 wv 1 en %h", k, bus.grant_id, bus.wr_valid, bus.rf_enable, 32'h80000000); end
    end
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    set_req(1, 5'd7, 32'h7777_7777);
    bus.req_valid = 3'b010;
    tick();
    checks++; if (bus.rf_enable !== 32'h0000_0080) begin errors++; $display("FAIL midrst_en_before got %h want %h", bus.rf_enable, 32'h80); end
    reset         = 1'b1;
    bus.req_valid = 3'b000;
    #1;
    checks++; if (bus.rf_enable !== 32'h0 || bus.wr_valid !== 1'b0 || bus.rf_data !== 32'h0)
      begin errors++; $display("FAIL midrst_async got en %h wv %b data %h want all 0", bus.rf_enable, bus.wr_valid, bus.rf_data); end
    tick();
    reset = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL midrst_pointer got %b want 001", bus.req_ready); end
    tick();
    checks++; if (bus.grant_id !== REQ_WB) begin errors++; $display("FAIL midrst_first_id got %0d want 0", bus.grant_id); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.rf_hold   = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_single_write();
    test_x0_write();
    test_contention();
    test_hold();
    test_single_repeat();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the register file among several requesters (core writeback, multi-cycle unit, debug port) with round-robin arbitration and a valid/ready handshake. It decodes the granted destination address into the one-hot per-register enables that drive the `enable` inputs of the register-file registers. It presents the write data on one registered output stage. Writes to x0 are accepted and discarded.

## Interface
- N, 32: data width of each register and of all data ports.
- NREQ, 3: number of requesters, 2..8. Requester 0 is core writeback by convention.
- NREGS, 32: number of registers. Address width ADDR_W = log2(NREGS) = 5.

- clk  in  1  clock. All state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rf_hold  in  1  freeze. While high, no new grants are issued.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*ADDR_W  packed destination addresses. Requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  NREQ*N  packed write data. Requester i occupies bits [i*N +: N].
- req_ready  out  NREQ  one-hot grant. The handshake for requester i completes when req_valid[i] and req_ready[i] are both high at a rising edge.
- rf_enable  out  NREGS  registered one-hot write enables to the register file. Bit 0 is never set.
- rf_data  out  N  registered write data, common to all registers.
- grant_id  out  log2(NREQ)  registered index of the requester whose write is currently on rf_*.
- wr_valid  out  1  registered. High when a handshake completed in the previous cycle, including x0 writes.

## Operation
- Round-robin pointer `last` holds the index of the most recently granted requester.
  - The priority search starts at (last+1) mod NREQ and wraps around.
  - `last` updates only in a cycle where a grant is issued.
- req_ready is combinational from req_valid, `last` and rf_hold.
  - At most one bit is set.
  - A bit is set only when the corresponding req_valid bit is high and rf_hold is low.
  - No bit is set when rf_hold is high or when no requester is valid.
- The granted requester's address and data are captured into the output stage on the handshake edge.
- The output stage is loaded every cycle:
  - After a handshake: rf_enable = decode(addr), or all zeros if addr = 0; rf_data = data; grant_id = index; wr_valid = 1.
  - Without a handshake: rf_enable = 0 and wr_valid = 0. rf_data and grant_id hold their previous values.
- There is no backpressure from the register file. The output stage never stalls, so the arbiter sustains one write per cycle.
- Requesters must hold valid, addr and data stable until the handshake completes. The arbiter does not check this; the bench asserts it.
- rf_hold rising does not cancel the write already in the output stage. That write completes in the following cycle.

## Timing
- Reset values: last = NREQ-1, so requester 0 has top priority after reset. All other outputs reset to 0.
  - rf_enable = 0, rf_data = 0, grant_id = 0, wr_valid = 0, req_ready = 0.
- Latency: a handshake at edge t drives rf_enable and rf_data during cycle t+1. The register-file register captures the data at edge t+1, so the write is visible on that register's output after t+1.
- Back-to-back: a requester that holds valid is re-granted only after every other valid requester has been served once.
- Simultaneous valid from all requesters: grants rotate in the order last+1, last+2, …, one per cycle.
- A single valid requester with no contention is granted every cycle.
- Reset asserted mid-operation clears the output stage immediately (asynchronous). A write that was in flight is lost, and the requester receives no second handshake.
- Reset deasserts synchronously to clk. This is the system integrator's responsibility.

## Structure
- Shared package `regfile_pkg` holds:
  - ADDR_W;
  - the constant REG_ZERO = 0;
  - the requester index typedef `req_id_t` (log2(NREQ) bits);
  - the named requester indices REQ_WB = 0, REQ_MC = 1, REQ_DBG = 2.
- Sub-module `regfile_rr_arbiter` is purely combinational.
  - Inputs: valid vector, `last`, hold.
  - Outputs: one-hot grant and encoded index.
- The top level contains `last`, the output stage, and the address decoder.

## Test plan
- Reset: hold reset high with all req_valid = 1.
  - Required: every output is 0 and req_ready = 0.
  - Release reset: the first grant goes to requester 0.
- Single write: req 1 writes addr 5 with data 0xDEADBEEF.
  - Required: one cycle later, rf_enable = 0x0000_0020, rf_data = 0xDEADBEEF, grant_id = 1, wr_valid = 1.
  - Required: the next cycle, rf_enable = 0.
- x0 write: req 0 writes addr 0 with data 0x1234.
  - Required: the handshake completes, wr_valid = 1, rf_enable = 0.
- Contention: all three requesters valid continuously for 6 cycles after reset.
  - Required grant order: 0, 1, 2, 0, 1, 2, with one wr_valid per cycle.
- Hold: rf_hold goes high on the cycle after req 2 is granted.
  - Required: req 2's write still appears on rf_enable. No req_ready is set while rf_hold is high. Rotation resumes at requester 0 when rf_hold falls.
- Reset mid-write: assert reset in the cycle after a handshake (req 1, addr 7).
  - Required: rf_enable drops to 0 within the same cycle, without waiting for a clock edge.
  - Required: after release, the pointer is back at NREQ-1.
